bus_region_ctrl: RTL and testbench

Parametrised memory/IO region controller for the 8088 bus, replacing the fixed single-select read/write FSM. Decodes the ALE-latched address into NUM_REGIONS chip selects, with separate memory and IO maps. Inserts per-region programmable wait states by holding READY low. Flags accesses to unmapped addresses. Sits between the 8282 address latch / 8286 transceiver and the memory and IO devices.

---
 rtl/bus_region_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bus_region_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_region_ctrl.sv
// bus_region_ctrl: 8088 bus region decoder with per-region wait states and bus error flagging.
//
// Parameters
//   NUM_REGIONS  number of decoded regions (1..8)
//   ADDR_W       address width
//   WAIT_W       wait-state count width per region
//   REGION_BASE  packed base addresses, region k at [k*ADDR_W +: ADDR_W]
//   REGION_MASK  packed compare masks, 1 = bit compared
//   REGION_IO    per-region space select, 1 = IO cycles, 0 = memory cycles
//
// Ports
//   CLK       bus clock
//   RESET_N   asynchronous active-low reset
//   ALE       address latch enable; starts (or aborts and restarts) a bus cycle
//   IOM       1 = IO cycle, 0 = memory cycle
//   RD_N      CPU read strobe, active low
//   WR_N      CPU write strobe, active low
//   ADDR      latched bus address
//   WAIT_CFG  per-region wait states, sampled on the strobe edge
//   CS_N      one-hot-cold chip selects
//   OE        device read enable
//   WE        device write enable
//   READY     CPU READY; low inserts wait states
//   BUS_ERR   one-cycle pulse on an unmapped or illegal access
//   ERR_CNT   saturating count of BUS_ERR pulses
//
// Build option
//   BUSCTRL_TIMEOUT_EN  when defined, 15 strobe-less cycles in ADDR raise a bus error.
module bus_region_ctrl #(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            ADDR_W      = 20,
    parameter int                            WAIT_W      = 3,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS-1:0]        REGION_IO   = '0
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          ALE,
    input  logic                          IOM,
    input  logic                          RD_N,
    input  logic                          WR_N,
    input  logic [ADDR_W-1:0]             ADDR,
    input  logic [NUM_REGIONS*WAIT_W-1:0] WAIT_CFG,
    output logic [NUM_REGIONS-1:0]        CS_N,
    output logic                          OE,
    output logic                          WE,
    output logic                          READY,
    output logic                          BUS_ERR,
    output logic [7:0]                    ERR_CNT
);
    localparam int HW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_XFER = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]        state, nxt;
    logic [HW-1:0]     hit, lk_hit, sel_hit;
    logic              hit_v, lk_v, sel_v;
    logic [WAIT_W-1:0] cnt, nxt_cnt, cfg;
    logic              rd, nxt_rd;
    logic              strobe, both_low, to_hit, busy, err_entry;

    // Address decode on the live bus; lowest matching index wins, so scan downwards.
    always_comb begin
        hit   = '0;
        hit_v = 1'b0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if ((((ADDR ^ REGION_BASE[k*ADDR_W +: ADDR_W]) & REGION_MASK[k*ADDR_W +: ADDR_W]) == '0)
                && (REGION_IO[k] == IOM)) begin
                hit   = HW'(k);
                hit_v = 1'b1;
            end
        end
    end

    assign strobe   = RD_N ^ WR_N;
    assign both_low = ~RD_N & ~WR_N;
    assign cfg      = WAIT_CFG[int'(lk_hit)*WAIT_W +: WAIT_W];
    // An ALE edge supplies a fresh decode; otherwise the latched one stays in force.
    assign sel_hit  = ALE ? hit : lk_hit;
    assign sel_v    = ALE ? hit_v : lk_v;

`ifdef BUSCTRL_TIMEOUT_EN
    logic [3:0] to_cnt;
    // to_cnt counts completed strobe-less ADDR cycles; the 15th one trips.
    assign to_hit = to_cnt == 4'd14;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            to_cnt <= '0;
        else
            to_cnt <= (state == S_ADDR && !ALE && nxt == S_ADDR) ? to_cnt + 4'd1 : 4'd0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        nxt_cnt = cnt;
        nxt_rd  = rd;
        if (ALE) begin
            nxt     = S_ADDR;
            nxt_cnt = '0;
        end else begin
            case (state)
                S_IDLE: nxt = S_IDLE;
                S_ADDR: begin
                    if (both_low)
                        nxt = S_ERR;
                    else if (strobe) begin
                        if (!lk_v)
                            nxt = S_ERR;
                        else begin
                            nxt_rd  = ~RD_N;
                            nxt_cnt = cfg;
                            nxt     = (cfg == '0) ? S_XFER : S_WAIT;
                        end
                    end else if (to_hit)
                        nxt = S_ERR;
                end
                S_WAIT: begin
                    nxt_cnt = cnt - 1'b1;
                    nxt     = (cnt == WAIT_W'(1)) ? S_XFER : S_WAIT;
                end
                S_XFER: nxt = (rd ? RD_N : WR_N) ? S_IDLE : S_XFER;
                S_ERR:  nxt = (RD_N && WR_N) ? S_IDLE : S_ERR;
                default: nxt = S_IDLE;
            endcase
        end
    end

    assign busy      = nxt == S_ADDR || nxt == S_WAIT || nxt == S_XFER;
    assign err_entry = nxt == S_ERR && state != S_ERR;

    // Outputs are registered from the next state so they change on the deciding edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rd      <= 1'b0;
            lk_hit  <= '0;
            lk_v    <= 1'b0;
            CS_N    <= '1;
            OE      <= 1'b0;
            WE      <= 1'b0;
            READY   <= 1'b1;
            BUS_ERR <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            state   <= nxt;
            cnt     <= nxt_cnt;
            rd      <= nxt_rd;
            lk_hit  <= sel_hit;
            lk_v    <= sel_v;
            CS_N    <= (busy && sel_v) ? ~(NUM_REGIONS'(1) << sel_hit) : '1;
            OE      <= nxt == S_XFER && nxt_rd;
            WE      <= nxt == S_XFER && !nxt_rd;
            READY   <= nxt != S_WAIT;
            BUS_ERR <= err_entry;
            ERR_CNT <= (err_entry && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
        end
    end
endmodule

// File: tb/tb_bus_region_ctrl.sv
// tb_bus_region_ctrl: scoreboard bench for bus_region_ctrl with directed, hand-computed vectors.
module tb_bus_region_ctrl;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ALE = 1'b0;
    logic        IOM = 1'b0;
    logic        RD_N = 1'b1;
    logic        WR_N = 1'b1;
    logic [19:0] ADDR = '0;
    logic [11:0] WAIT_CFG = {3'd3, 3'd0, 3'd2, 3'd1};
    logic [3:0]  CS_N;
    logic        OE, WE, READY, BUS_ERR;
    logic [7:0]  ERR_CNT;

    // r0 mem C0000/F0000, r1 mem 80000/80000, r2 IO 08000/08000, r3 IO 00100/FFF00
    bus_region_ctrl #(
        .NUM_REGIONS(4), .ADDR_W(20), .WAIT_W(3),
        .REGION_BASE({20'h00100, 20'h08000, 20'h80000, 20'hC0000}),
        .REGION_MASK({20'hFFF00, 20'h08000, 20'h80000, 20'hF0000}),
        .REGION_IO(4'b1100)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ALE(ALE), .IOM(IOM), .RD_N(RD_N), .WR_N(WR_N),
        .ADDR(ADDR), .WAIT_CFG(WAIT_CFG), .CS_N(CS_N), .OE(OE), .WE(WE), .READY(READY),
        .BUS_ERR(BUS_ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          ph;
        logic [15:0] v;
        string       nm;
    } exp_t;
    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    wire [15:0] obs = {CS_N, OE, WE, READY, BUS_ERR, ERR_CNT};

    function automatic logic [15:0] ev(logic [3:0] cs, logic oe, logic we, logic rdy, logic be, logic [7:0] cnt);
        return {cs, oe, we, rdy, be, cnt};
    endfunction

    task automatic chk(input int ph);
        exp_t e;
        while (q.size() > 0 && (q[0].cyc < cyc || (q[0].cyc == cyc && q[0].ph <= ph))) begin
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: cs_n,oe,we,ready,bus_err,err_cnt got %h want %h (cycle %0d, due %0d)",
                         e.nm, obs, e.v, cyc, e.cyc);
            end
        end
    endtask

    // Monitor: phase 0 at the falling edge, phase 1 shortly after for asynchronous effects.
    always @(negedge CLK) begin
        chk(0);
        #2;
        chk(1);
    end

    task automatic step(input logic ale, input logic iom, input logic rd, input logic wr,
                        input logic [19:0] a, input logic [15:0] ex, input string nm);
        ALE = ale; IOM = iom; RD_N = rd; WR_N = wr; ADDR = a;
        q.push_back('{cyc + 1, 0, ex, nm});
        @(posedge CLK); #1;
    endtask

    int base, c, p;

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        step(0, 0, 1, 1, 20'h0, ev(4'hF, 0, 0, 1, 0, 8'd0), "reset_state");
        RESET_N = 1'b1;
        step(0, 0, 1, 1, 20'h0, ev(4'hF, 0, 0, 1, 0, 8'd0), "idle");

        // Memory read, region 1, two wait states; WAIT_CFG poked mid-wait must be ignored
        step(1, 0, 1, 1, 20'h81234, ev(4'hD, 0, 0, 1, 0, 8'd0), "rd_cs");
        step(0, 0, 0, 1, 20'h81234, ev(4'hD, 0, 0, 0, 0, 8'd0), "rd_wait1");
        WAIT_CFG[5:3] = 3'd7;
        step(0, 0, 0, 1, 20'h81234, ev(4'hD, 0, 0, 0, 0, 8'd0), "rd_wait2");
        step(0, 0, 0, 1, 20'h81234, ev(4'hD, 1, 0, 1, 0, 8'd0), "rd_oe");
        step(0, 0, 0, 1, 20'h81234, ev(4'hD, 1, 0, 1, 0, 8'd0), "rd_hold");
        WAIT_CFG[5:3] = 3'd2;
        step(0, 0, 1, 1, 20'h81234, ev(4'hF, 0, 0, 1, 0, 8'd0), "rd_release");

        // IO write, region 2, zero wait states
        step(1, 1, 1, 1, 20'h08010, ev(4'hB, 0, 0, 1, 0, 8'd0), "wr_cs");
        step(0, 1, 1, 0, 20'h08010, ev(4'hB, 0, 1, 1, 0, 8'd0), "wr_we");
        step(0, 1, 1, 0, 20'h08010, ev(4'hB, 0, 1, 1, 0, 8'd0), "wr_hold");
        step(0, 1, 1, 1, 20'h08010, ev(4'hF, 0, 0, 1, 0, 8'd0), "wr_release");

        // Unmapped memory read
        step(1, 0, 1, 1, 20'h00010, ev(4'hF, 0, 0, 1, 0, 8'd0), "unm_addr");
        step(0, 0, 0, 1, 20'h00010, ev(4'hF, 0, 0, 1, 1, 8'd1), "unm_err");
        step(0, 0, 0, 1, 20'h00010, ev(4'hF, 0, 0, 1, 0, 8'd1), "unm_pulse_end");
        step(0, 0, 1, 1, 20'h00010, ev(4'hF, 0, 0, 1, 0, 8'd1), "unm_idle");

        // Overlapping regions 0 and 1: region 0 wins, one wait state
        step(1, 0, 1, 1, 20'hC1000, ev(4'hE, 0, 0, 1, 0, 8'd1), "pri_cs");
        step(0, 0, 0, 1, 20'hC1000, ev(4'hE, 0, 0, 0, 0, 8'd1), "pri_wait");
        step(0, 0, 0, 1, 20'hC1000, ev(4'hE, 1, 0, 1, 0, 8'd1), "pri_oe");
        step(0, 0, 1, 1, 20'hC1000, ev(4'hF, 0, 0, 1, 0, 8'd1), "pri_release");

        // Both strobes low
        step(1, 0, 1, 1, 20'h81234, ev(4'hD, 0, 0, 1, 0, 8'd1), "ill_cs");
        step(0, 0, 0, 0, 20'h81234, ev(4'hF, 0, 0, 1, 1, 8'd2), "ill_err");
        step(0, 0, 1, 1, 20'h81234, ev(4'hF, 0, 0, 1, 0, 8'd2), "ill_idle");

        // ALE during WAIT aborts and restarts without an error
        step(1, 0, 1, 1, 20'h81234, ev(4'hD, 0, 0, 1, 0, 8'd2), "abt_cs");
        step(0, 0, 0, 1, 20'h81234, ev(4'hD, 0, 0, 0, 0, 8'd2), "abt_wait");
        step(1, 1, 1, 1, 20'h08010, ev(4'hB, 0, 0, 1, 0, 8'd2), "abt_recap");
        step(0, 1, 1, 0, 20'h08010, ev(4'hB, 0, 1, 1, 0, 8'd2), "abt_we");
        step(0, 1, 1, 1, 20'h08010, ev(4'hF, 0, 0, 1, 0, 8'd2), "abt_release");

        // Reset asserted during WAIT with 3 counts remaining
        step(1, 1, 1, 1, 20'h00105, ev(4'h7, 0, 0, 1, 0, 8'd2), "rst_cs");
        step(0, 1, 0, 1, 20'h00105, ev(4'h7, 0, 0, 0, 0, 8'd2), "rst_wait");
        @(negedge CLK); #1;
        RESET_N = 1'b0; RD_N = 1'b1; IOM = 1'b0;
        q.push_back('{cyc, 1, ev(4'hF, 0, 0, 1, 0, 8'd0), "rst_async"});
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        step(1, 1, 1, 1, 20'h08010, ev(4'hB, 0, 0, 1, 0, 8'd0), "post_rst_cs");
        step(0, 1, 1, 0, 20'h08010, ev(4'hB, 0, 1, 1, 0, 8'd0), "post_rst_we");
        step(0, 1, 1, 1, 20'h08010, ev(4'hF, 0, 0, 1, 0, 8'd0), "post_rst_release");

        // Strobe-less ADDR phase
        step(1, 0, 1, 1, 20'h81234, ev(4'hD, 0, 0, 1, 0, 8'd0), "to_cs");
        for (int j = 1; j <= 20; j++) begin
`ifdef BUSCTRL_TIMEOUT_EN
            if (j < 15)
                step(0, 0, 1, 1, 20'h81234, ev(4'hD, 0, 0, 1, 0, 8'd0), "to_wait");
            else if (j == 15)
                step(0, 0, 1, 1, 20'h81234, ev(4'hF, 0, 0, 1, 1, 8'd1), "to_err");
            else
                step(0, 0, 1, 1, 20'h81234, ev(4'hF, 0, 0, 1, 0, 8'd1), "to_idle");
`else
            step(0, 0, 1, 1, 20'h81234, ev(4'hD, 0, 0, 1, 0, 8'd0), "noto_hold");
`endif
        end
`ifdef BUSCTRL_TIMEOUT_EN
        base = 1;
`else
        base = 0;
`endif

        // 256 illegal accesses: counter saturates at 255 while BUS_ERR keeps pulsing
        for (int i = 0; i < 256; i++) begin
            p = (base + i > 255) ? 255 : base + i;
            c = (base + i + 1 > 255) ? 255 : base + i + 1;
            step(1, 0, 1, 1, 20'h81234, ev(4'hD, 0, 0, 1, 0, p[7:0]), "sat_cs");
            step(0, 0, 0, 0, 20'h81234, ev(4'hF, 0, 0, 1, 1, c[7:0]), "sat_err");
            step(0, 0, 1, 1, 20'h81234, ev(4'hF, 0, 0, 1, 0, c[7:0]), "sat_idle");
        end
        step(0, 0, 1, 1, 20'h0, ev(4'hF, 0, 0, 1, 0, 8'd255), "sat_final");

        repeat (2) @(negedge CLK);
        #3;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
